// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: double-buffered BRAM controller. A producer fills one bank while
// the consumer drains the other, and ownership swaps when a frame is done.
// Optional feature: define PINGPONG_PERF_CNT_EN to build the swap/stall counters.
module pingpong_ctrl #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ARM_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              start_write,
  input  logic              busy_write,
  output logic              start_read,
  input  logic              busy_read,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              bram0_we,
  output logic [ADDR_W-1:0] bram0_addr,
  output logic [DATA_W-1:0] bram0_din,
  input  logic [DATA_W-1:0] bram0_dout,
  output logic              bram1_we,
  output logic [ADDR_W-1:0] bram1_addr,
  output logic [DATA_W-1:0] bram1_din,
  input  logic [DATA_W-1:0] bram1_dout,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [1:0]        full,
  output logic              err,
  output logic [15:0]       swap_cnt,
  output logic [15:0]       rd_stall_cnt
);

  localparam int unsigned TO_W = $clog2(ARM_TIMEOUT + 2);

  typedef enum logic [1:0] {W_IDLE, W_ARM, W_BUSY, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ARM, R_BUSY, R_DONE} r_state_t;

  w_state_t        w_state;
  r_state_t        r_state;
  logic [TO_W-1:0] w_cnt;
  logic [TO_W-1:0] r_cnt;
  logic            wr_active;
  logic            w_start_ok;
  logic            r_start_ok;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;

  // Start guards and per-bank full flag updates for this cycle
  always_comb begin
    wr_active  = (w_state == W_ARM) || (w_state == W_BUSY);
    w_start_ok = en && !busy_write && !full[wr_bank];
    r_start_ok = en && !busy_read && full[rd_bank] && !(wr_active && (wr_bank == rd_bank));
    full_set   = 2'b00;
    full_clr   = 2'b00;
    if (w_state == W_DONE) full_set[wr_bank] = 1'b1;
    if (r_state == R_DONE) full_clr[rd_bank] = 1'b1;
  end

  // Writer and reader FSMs, bank ownership, full flags and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      r_state     <= R_IDLE;
      w_cnt       <= '0;
      r_cnt       <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      err         <= 1'b0;
    end else begin
      start_write <= 1'b0;
      start_read  <= 1'b0;
      full        <= (full | full_set) & ~full_clr;

      case (w_state)
        W_IDLE: if (w_start_ok) begin
          w_state     <= W_ARM;
          start_write <= 1'b1;
          w_cnt       <= '0;
        end
        W_ARM: begin
          if (busy_write) begin
            w_state <= W_BUSY;
          end else if (w_cnt == TO_W'(ARM_TIMEOUT)) begin
            w_state <= W_IDLE;
            err     <= 1'b1;
          end else begin
            w_cnt <= w_cnt + TO_W'(1);
          end
        end
        W_BUSY: if (!busy_write) w_state <= W_DONE;
        W_DONE: begin
          wr_bank <= ~wr_bank;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase

      case (r_state)
        R_IDLE: if (r_start_ok) begin
          r_state    <= R_ARM;
          start_read <= 1'b1;
          r_cnt      <= '0;
        end
        R_ARM: begin
          if (busy_read) begin
            r_state <= R_BUSY;
          end else if (r_cnt == TO_W'(ARM_TIMEOUT)) begin
            r_state <= R_IDLE;
            err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        R_BUSY: if (!busy_read) r_state <= R_DONE;
        R_DONE: begin
          rd_bank <= ~rd_bank;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Bank port steering: writer owns its bank while arming/busy, reader otherwise
  always_comb begin
    bram0_we   = 1'b0;
    bram0_addr = rd_addr;
    bram0_din  = '0;
    bram1_we   = 1'b0;
    bram1_addr = rd_addr;
    bram1_din  = '0;
    if (wr_active && !wr_bank) begin
      bram0_we   = 1'b1;
      bram0_addr = wr_addr;
      bram0_din  = wr_data;
    end
    if (wr_active && wr_bank) begin
      bram1_we   = 1'b1;
      bram1_addr = wr_addr;
      bram1_din  = wr_data;
    end
    rd_data = rd_bank ? bram1_dout : bram0_dout;
  end

`ifdef PINGPONG_PERF_CNT_EN
  localparam int unsigned CNT_W = 16;

  // Saturating frame-swap and reader-starved counters
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_cnt     <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if ((r_state == R_DONE) && (swap_cnt != '1))
        swap_cnt <= swap_cnt + CNT_W'(1);
      if ((r_state == R_IDLE) && en && (full == 2'b00) && (rd_stall_cnt != '1))
        rd_stall_cnt <= rd_stall_cnt + CNT_W'(1);
    end
  end
`else
  assign swap_cnt     = '0;
  assign rd_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with producer/consumer responders and BRAM models.
module tb_pingpong_ctrl;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
`ifdef PINGPONG_PERF_CNT_EN
  localparam logic [15:0] EXP_SWAP  = 16'd4;
  localparam logic [15:0] EXP_STALL = 16'd20;
`else
  localparam logic [15:0] EXP_SWAP  = 16'd0;
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic              clk = 1'b0;
  logic              rst, en;
  logic              start_write, busy_write, start_read, busy_read;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              bram0_we, bram1_we;
  logic [ADDR_W-1:0] bram0_addr, bram1_addr;
  logic [DATA_W-1:0] bram0_din, bram1_din, bram0_dout, bram1_dout;
  logic              wr_bank, rd_bank, err;
  logic [1:0]        full;
  logic [15:0]       swap_cnt, rd_stall_cnt;

  logic [DATA_W-1:0] mem0 [0:63];
  logic [DATA_W-1:0] mem1 [0:63];

  int   errors = 0;
  int   checks = 0;
  bit   prod_on = 1'b0;
  bit   cons_hold = 1'b0;
  int   prod_len = 9;
  int   cons_len = 11;
  int   wr_cnt, rd_cnt, prod_idx, cons_idx, we_viol;
  int   cyc = 0;
  int   first_sw, first_full;
  int   n;
  logic wr_bank_log [0:7];
  logic rd_bank_log [0:7];
  logic [7:0] rd_data_log [0:7][0:7];

  always #5 clk = ~clk;

  pingpong_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .start_write(start_write), .busy_write(busy_write),
    .start_read(start_read), .busy_read(busy_read),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .bram0_we(bram0_we), .bram0_addr(bram0_addr), .bram0_din(bram0_din), .bram0_dout(bram0_dout),
    .bram1_we(bram1_we), .bram1_addr(bram1_addr), .bram1_din(bram1_din), .bram1_dout(bram1_dout),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .full(full), .err(err),
    .swap_cnt(swap_cnt), .rd_stall_cnt(rd_stall_cnt)
  );

  // Single-port BRAMs with one-cycle read latency
  always @(posedge clk) begin
    if (bram0_we) mem0[bram0_addr] <= bram0_din;
    bram0_dout <= mem0[bram0_addr];
    if (bram1_we) mem1[bram1_addr] <= bram1_din;
    bram1_dout <= mem1[bram1_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cnt = 0; rd_cnt = 0; prod_idx = 0; cons_idx = 0; we_viol = 0;
    first_sw = -1; first_full = -1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_logs();
  endtask

  // Producer: on a start pulse, hold busy prod_len cycles writing data = frame*16 + addr
  initial begin : producer
    forever begin
      @(posedge clk); #1;
      if (prod_on && start_write) begin
        wr_addr = '0;
        wr_data = DATA_W'(prod_idx * 16);
        busy_write = 1'b1;
        for (int i = 1; i <= prod_len; i++) begin
          @(posedge clk); #1;
          wr_addr = ADDR_W'(i);
          wr_data = DATA_W'(prod_idx * 16 + i);
          if (i == prod_len) busy_write = 1'b0;
        end
        prod_idx++;
      end
    end
  end

  // Consumer: on a start pulse, sweep rd_addr and capture rd_data one cycle later
  initial begin : consumer
    forever begin
      @(posedge clk); #1;
      if (start_read) begin
        rd_addr = '0;
        busy_read = 1'b1;
        for (int i = 1; i <= cons_len; i++) begin
          @(posedge clk); #1;
          if ((rd_bank ? bram1_we : bram0_we) !== 1'b0) we_viol++;
          if (i <= 8 && cons_idx < 8) rd_data_log[cons_idx][i-1] = rd_data;
          rd_addr = ADDR_W'(i);
        end
        while (cons_hold) begin @(posedge clk); #1; end
        busy_read = 1'b0;
        cons_idx++;
      end
    end
  end

  // Start-pulse and first-full monitor
  initial begin : monitor
    forever begin
      @(posedge clk); cyc++; #2;
      if (start_write === 1'b1) begin
        if (wr_cnt < 8) wr_bank_log[wr_cnt] = wr_bank;
        if (first_sw < 0) first_sw = cyc;
        wr_cnt++;
      end
      if (start_read === 1'b1) begin
        if (rd_cnt < 8) rd_bank_log[rd_cnt] = rd_bank;
        rd_cnt++;
      end
      if (full[0] === 1'b1 && first_full < 0) first_full = cyc;
    end
  end

  initial begin : main
    rst = 1'b1; en = 1'b1; busy_write = 1'b0; busy_read = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    clear_logs();

    // Reset state, with en high during reset to show reset wins
    @(negedge clk); @(negedge clk);
    chk("rst_start_write", 32'(start_write), 0);
    chk("rst_start_read", 32'(start_read), 0);
    chk("rst_wr_bank", 32'(wr_bank), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_swap_cnt", 32'(swap_cnt), 0);
    chk("rst_stall_cnt", 32'(rd_stall_cnt), 0);
    chk("rst_bram0_we", 32'(bram0_we), 0);
    chk("rst_bram1_we", 32'(bram1_we), 0);

    // Stall counter: en low does not count, en high with empty banks does
    rst = 1'b0; en = 1'b0; clear_logs();
    repeat (20) @(negedge clk);
    chk("stall_en_low", 32'(rd_stall_cnt), 0);
    en = 1'b1;
    repeat (20) @(negedge clk);
    chk("stall_en_high", 32'(rd_stall_cnt), 32'(EXP_STALL));
    chk("stall_full_empty", 32'(full), 0);
    en = 1'b0;
    repeat (10) @(negedge clk);

    // Four frames through the ping-pong
    do_reset();
    prod_on = 1'b1;
    en = 1'b1;
    n = 0;
    while (rd_cnt < 4 && n < 2000) begin @(negedge clk); n++; end
    en = 1'b0;
    chk("frames_reads_started", 32'(rd_cnt), 4);
    repeat (80) @(negedge clk);
    chk("frames_no_more_reads", 32'(rd_cnt), 4);
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("wr_bank_frame%0d", f), 32'(wr_bank_log[f]), 32'(f % 2));
      chk($sformatf("rd_bank_frame%0d", f), 32'(rd_bank_log[f]), 32'(f % 2));
    end
    chk("frames_swap_cnt", 32'(swap_cnt), 32'(EXP_SWAP));
    chk("frames_err", 32'(err), 0);
    chk("latency_start_to_full", 32'(first_full - first_sw), 11);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rd_data_f0_a%0d", k), 32'(rd_data_log[0][k]), 32'(k));
      chk($sformatf("rd_data_f1_a%0d", k), 32'(rd_data_log[1][k]), 32'(16 + k));
    end
    chk("read_bank_we_low", 32'(we_viol), 0);

    // Consumer stuck busy: producer fills the second bank then stalls
    do_reset();
    cons_hold = 1'b1;
    en = 1'b1;
    repeat (100) @(negedge clk);
    chk("stuck_full", 32'(full), 3);
    chk("stuck_wr_starts", 32'(wr_cnt), 2);
    chk("stuck_rd_starts", 32'(rd_cnt), 1);
    chk("stuck_wr_bank", 32'(wr_bank), 0);
    en = 1'b0;
    cons_hold = 1'b0;
    repeat (40) @(negedge clk);

    // Producer never answers: timeout sets sticky err five cycles after the pulse
    do_reset();
    prod_on = 1'b0;
    busy_write = 1'b0;
    en = 1'b1;
    n = 0;
    while (start_write !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("to_pulse_seen", 32'(start_write), 1);
    repeat (4) @(negedge clk);
    chk("to_err_before", 32'(err), 0);
    @(negedge clk);
    chk("to_err_set", 32'(err), 1);
    chk("to_full_unchanged", 32'(full), 0);
    @(negedge clk);
    chk("to_rearm_from_idle", 32'(start_write), 1);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("to_err_sticky", 32'(err), 1);

    // Reset mid-transfer while the producer still reports busy
    do_reset();
    chk("midrst_err_cleared", 32'(err), 0);
    en = 1'b1;
    n = 0;
    while (start_write !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("midrst_pulse_seen", 32'(start_write), 1);
    busy_write = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_full", 32'(full), 0);
    chk("midrst_wr_bank", 32'(wr_bank), 0);
    chk("midrst_start_0", 32'(start_write), 0);
    @(negedge clk);
    chk("midrst_start_1", 32'(start_write), 0);
    @(negedge clk);
    chk("midrst_start_2", 32'(start_write), 0);
    busy_write = 1'b0;
    @(negedge clk);
    chk("midrst_start_after_idle", 32'(start_write), 1);
    chk("midrst_full_after", 32'(full), 0);
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
